// File: rtl/risc_pkg.sv
// Shared loader definitions: state type, default NOP encoding and the state transition rule.
package risc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } ld_state_e;

    // RV32I "addi x0, x0, 0"
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

    // load_start has priority over load_done; load_done only matters while loading.
    function automatic ld_state_e ld_next(input ld_state_e cur,
                                          input logic      start,
                                          input logic      done);
        ld_state_e nxt;
        nxt = cur;
        if (start) begin
            nxt = ST_LOAD;
        end else if (done && (cur == ST_LOAD)) begin
            nxt = ST_RUN;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-wide load port plus word fetch port between the loader and its host/core.
interface imem_loader_if #(
    parameter int ADDR_W = 7,
    parameter int WORD_W = 32
);
    localparam int LANES = WORD_W / 8;
    localparam int DEPTH = (2 ** ADDR_W) / LANES;
    localparam int FA_W  = $clog2(DEPTH);

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic [FA_W:0]     fetch_addr;
    logic [WORD_W-1:0] fetch_data;

    modport master (
        output wr_valid, wr_addr, wr_data, fetch_addr,
        input  wr_ready, fetch_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, fetch_addr,
        output wr_ready, fetch_data
    );

endinterface

// File: rtl/imem_bytewrite_ram.sv
// Instruction memory: DEPTH x WORD_W words, per-byte-lane write, registered read, no reset.
module imem_bytewrite_ram #(
    parameter int DEPTH  = 32,
    parameter int WORD_W = 32,
    parameter int FA_W   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [WORD_W/8-1:0]   wr_be,
    input  logic [FA_W-1:0]       wr_word,
    input  logic [7:0]            wr_byte,
    input  logic [FA_W-1:0]       rd_addr,
    output logic [WORD_W-1:0]     rd_data
);
    localparam int LANES = WORD_W / 8;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_word][i*8 +: 8] <= wr_byte;
                end
            end
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte-wise image load, then word fetch for the core.
// Optional IMEM_CHECKSUM_EN adds an 8-bit running sum of the bytes accepted since load_start.
//
// state   | meaning
// IDLE    | after reset; no writes accepted, core held, fetch returns NOP
// LOAD    | bytes accepted on the load port, core held, fetch returns NOP
// RUN     | core running, fetch returns memory words (NOP when out of range)
module imem_loader
    import risc_pkg::*;
#(
    parameter int                ADDR_W   = 7,
    parameter int                WORD_W   = 32,
    parameter logic [WORD_W-1:0] NOP_WORD = WORD_W'(NOP_WORD_DEF)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_start,
    input  logic              load_done,
    output logic              core_run,
    output logic [ADDR_W:0]   bytes_loaded,
`ifdef IMEM_CHECKSUM_EN
    output logic [7:0]        checksum,
`endif
    imem_loader_if.slave      bus
);
    localparam int LANES = WORD_W / 8;
    localparam int DEPTH = (2 ** ADDR_W) / LANES;
    localparam int FA_W  = $clog2(DEPTH);

    localparam logic [ADDR_W:0] BYTES_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [FA_W:0]   DEPTH_W   = DEPTH[FA_W:0];

    ld_state_e         state;
    ld_state_e         state_nxt;
    logic              fetch_nop;
    logic              wr_en;
    logic [LANES-1:0]  wr_be;
    logic [FA_W-1:0]   wr_word;
    logic [WORD_W-1:0] rd_word;

    assign state_nxt = ld_next(state, load_start, load_done);
    assign core_run  = (state == ST_RUN);

    assign wr_en   = bus.wr_valid && bus.wr_ready;
    assign wr_word = FA_W'(bus.wr_addr >> $clog2(LANES));
    assign wr_be   = LANES'(1) << (bus.wr_addr & ADDR_W'(LANES - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= ST_IDLE;
            bus.wr_ready <= 1'b0;
            bytes_loaded <= '0;
            fetch_nop    <= 1'b1;
        end else begin
            state        <= state_nxt;
            bus.wr_ready <= (state_nxt == ST_LOAD);
            // The word read at this edge is only meaningful if we are running now.
            fetch_nop    <= !((state == ST_RUN) && (bus.fetch_addr < DEPTH_W));
            if (load_start) begin
                bytes_loaded <= '0;
            end else if (wr_en && (bytes_loaded != BYTES_MAX)) begin
                bytes_loaded <= bytes_loaded + 1'b1;
            end
        end
    end

`ifdef IMEM_CHECKSUM_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            checksum <= 8'h00;
        end else if (load_start) begin
            checksum <= 8'h00;
        end else if (wr_en) begin
            checksum <= checksum + bus.wr_data;
        end
    end
`endif

    imem_bytewrite_ram #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .FA_W   (FA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_be   (wr_be),
        .wr_word (wr_word),
        .wr_byte (bus.wr_data),
        .rd_addr (bus.fetch_addr[FA_W-1:0]),
        .rd_data (rd_word)
    );

    assign bus.fetch_data = fetch_nop ? NOP_WORD : rd_word;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios then random traffic against a byte-image model.
module tb_imem_loader;
    localparam int ADDR_W = 7;
    localparam int WORD_W = 32;
    localparam int NBYTES = 128;
    localparam int DEPTH  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk        = 1'b0;
    logic            clr        = 1'b1;
    logic            load_start = 1'b0;
    logic            load_done  = 1'b0;
    logic            core_run;
    logic [ADDR_W:0] bytes_loaded;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]      checksum;
`endif

    imem_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .WORD_W   (WORD_W),
        .NOP_WORD (NOP)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .load_start   (load_start),
        .load_done    (load_done),
        .core_run     (core_run),
        .bytes_loaded (bytes_loaded),
`ifdef IMEM_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase, byte image, accepted-byte count and running sum.
    typedef enum {M_IDLE, M_LOAD, M_RUN} mphase_e;
    mphase_e    ph   = M_IDLE;
    logic [7:0] img [NBYTES];
    int         cnt  = 0;
    logic [7:0] csum = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int w);
        return {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
    endfunction

    // One clock cycle with the given inputs, then check every output against the model.
    task automatic cyc(input bit ls, input bit ld, input bit v,
                       input logic [6:0] a, input logic [7:0] d, input logic [5:0] fa);
        mphase_e     pre;
        logic [31:0] exp_fd;
        load_start     = ls;
        load_done      = ld;
        bus.wr_valid   = v;
        bus.wr_addr    = a;
        bus.wr_data    = d;
        bus.fetch_addr = fa;
        pre    = ph;
        exp_fd = ((pre == M_RUN) && (fa < DEPTH)) ? word_of(int'(fa)) : NOP;
        if ((pre == M_LOAD) && v) begin
            img[a] = d;
            if (cnt < NBYTES) cnt++;
            csum = csum + d;
        end
        if (ls) begin
            ph   = M_LOAD;
            cnt  = 0;
            csum = 8'h00;
        end else if (ld && (pre == M_LOAD)) begin
            ph = M_RUN;
        end
        @(posedge clk);
        #1;
        load_start   = 1'b0;
        load_done    = 1'b0;
        bus.wr_valid = 1'b0;
        chk("core_run",     {31'd0, core_run},     {31'd0, ph == M_RUN});
        chk("wr_ready",     {31'd0, bus.wr_ready}, {31'd0, ph == M_LOAD});
        chk("bytes_loaded", 32'(bytes_loaded),     32'(cnt));
        chk("fetch_data",   bus.fetch_data,        exp_fd);
`ifdef IMEM_CHECKSUM_EN
        chk("checksum",     32'(checksum),         32'(csum));
`endif
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        cyc(0, 0, 1, a, d, 6'd0);
    endtask

    task automatic fetch(input logic [5:0] fa);
        cyc(0, 0, 0, 7'd0, 8'd0, fa);
    endtask

    task automatic do_clr();
        #2 clr = 1'b1;
        #1;
        chk("clr_core_run", {31'd0, core_run},     32'd0);
        chk("clr_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        chk("clr_bytes",    32'(bytes_loaded),     32'd0);
        chk("clr_fetch",    bus.fetch_data,        NOP);
`ifdef IMEM_CHECKSUM_EN
        chk("clr_checksum", 32'(checksum),         32'd0);
`endif
        ph   = M_IDLE;
        cnt  = 0;
        csum = 8'h00;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        bus.wr_valid   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.fetch_addr = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_run", {31'd0, core_run},     32'd0);
        chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        chk("rst_bytes",    32'(bytes_loaded),     32'd0);
        chk("rst_fetch",    bus.fetch_data,        NOP);
        clr = 1'b0;

        fetch(6'd0);

        // First full load: known first word, then fill the image, then overflow the count.
        cyc(1, 0, 0, 7'd0, 8'd0, 6'd0);
        wr(7'd0, 8'h93);
        wr(7'd1, 8'h00);
        wr(7'd2, 8'h10);
        wr(7'd3, 8'h00);
        chk("bytes_after_4", 32'(bytes_loaded), 32'd4);
        for (int a = 4; a < NBYTES; a++) wr(7'(a), 8'($urandom));
        for (int k = 0; k < 3; k++) wr(7'($urandom_range(4, NBYTES - 1)), 8'($urandom));
        chk("bytes_saturated", 32'(bytes_loaded), 32'd128);
        cyc(0, 1, 0, 7'd0, 8'd0, 6'd0);

        fetch(6'd0);
        chk("word0_literal", bus.fetch_data, 32'h0010_0093);
        fetch(6'd32);
        chk("fetch_oob_32", bus.fetch_data, NOP);
        fetch(6'd63);
        for (int k = 0; k < 8; k++) fetch(6'($urandom_range(0, DEPTH - 1)));

        // Writes offered in RUN are ignored.
        cyc(0, 0, 1, 7'd4, ~img[4], 6'd1);
        fetch(6'd1);

        // Simultaneous start/done goes to LOAD, from RUN and from LOAD.
        cyc(1, 1, 0, 7'd0, 8'd0, 6'd0);
        chk("both_core_run", {31'd0, core_run}, 32'd0);
        cyc(1, 1, 0, 7'd0, 8'd0, 6'd2);
        wr(7'd8, 8'h11);
        wr(7'd8, 8'h22);
        for (int k = 0; k < 8; k++) wr(7'($urandom_range(8, 15)), 8'($urandom));
        cyc(0, 1, 0, 7'd0, 8'd0, 6'd2);
        fetch(6'd2);
        fetch(6'd3);

        // Reset in the middle of a load, load_done alone cannot resume, then reload.
        cyc(1, 0, 0, 7'd0, 8'd0, 6'd5);
        wr(7'd20, 8'hB7);
        wr(7'd21, 8'h02);
        do_clr();
        cyc(0, 1, 0, 7'd0, 8'd0, 6'd5);
        chk("done_after_clr", {31'd0, core_run}, 32'd0);
        cyc(1, 0, 0, 7'd0, 8'd0, 6'd5);
        wr(7'd20, 8'hB7);
        wr(7'd21, 8'h02);
        wr(7'd22, 8'h00);
        wr(7'd23, 8'h00);
        cyc(0, 1, 0, 7'd0, 8'd0, 6'd5);
        fetch(6'd5);
        chk("reload_word5", bus.fetch_data, 32'h0000_02B7);

`ifdef IMEM_CHECKSUM_EN
        cyc(1, 0, 0, 7'd0, 8'd0, 6'd0);
        wr(7'd40, 8'hFF);
        wr(7'd41, 8'h02);
        chk("checksum_ff_02", 32'(checksum), 32'h01);
        cyc(0, 1, 0, 7'd0, 8'd0, 6'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int         op;
            logic [5:0] fa;
            op = $urandom_range(0, 20);
            fa = 6'($urandom_range(0, 63));
            if (op == 0)      cyc(1, 0, 0, 7'd0, 8'd0, fa);
            else if (op <= 2) cyc(0, 1, 0, 7'd0, 8'd0, fa);
            else if (op == 3) cyc(1, 1, 0, 7'd0, 8'd0, fa);
            else if (op == 4) do_clr();
            else if (op <= 11) cyc(0, 0, 1, 7'($urandom), 8'($urandom), fa);
            else              cyc(0, 0, 0, 7'd0, 8'd0, fa);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
